driver_leds_rgb: RTL and testbench

Sequential, parametrised RGB LED driver for the memory-game board. It replaces the purely combinational one-hot-to-colour mapping with a registered colour latch, per-channel PWM brightness control and animated modes (fixed, blink, optional fade). It sits between the game datapath (selected play or colour code) and the RGB LED pins. It drives one RGB LED with glitch-free, frame-aligned updates.

---
 rtl/driver_leds_rgb.sv | 216 +++++++++++++++++++++
 tb/tb_driver_leds_rgb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/driver_leds_rgb.sv
// driver_leds_rgb: registered RGB LED driver for the memory-game board.
// A colour latch loaded from a one-hot code, per-frame PWM brightness and
// animated modes (fixed, blink and, when DRIVER_RGB_FADE_EN is defined, fade).
// Brightness and mode are only taken at frame end, so a PWM period is never cut.
module driver_leds_rgb #(
  parameter int LARGURA_DADOS = 4,
  parameter int LARGURA_PWM   = 8,
  parameter int DIV_PISCA     = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     carrega,
  input  logic [LARGURA_DADOS-1:0] dados,
  input  logic [LARGURA_PWM-1:0]   brilho,
  input  logic [1:0]               modo,
  output logic [2:0]               leds_rgb,
  output logic                     erro,
  output logic                     fim_quadro
);

  localparam int QW = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;
  localparam logic [QW-1:0] QUADRO_ULTIMO = QW'(DIV_PISCA - 1);
  localparam logic [LARGURA_PWM-1:0] PWM_MAX = {LARGURA_PWM{1'b1}};

`ifdef DRIVER_RGB_FADE_EN
  typedef enum logic {SUBINDO = 1'b0, DESCENDO = 1'b1} estado_t;
`endif

  // True when exactly one bit of the code is set (all-zero is rejected).
  function automatic logic eh_one_hot(input logic [LARGURA_DADOS-1:0] d);
    return (d != {LARGURA_DADOS{1'b0}}) &&
           ((d & (d - LARGURA_DADOS'(1))) == {LARGURA_DADOS{1'b0}});
  endfunction

  // Colour {B,R,G} for a one-hot code; only called on valid codes.
  function automatic logic [2:0] cor_de(input logic [LARGURA_DADOS-1:0] d);
    logic [2:0] c;
    c = 3'b000;
    for (int i = 0; i < LARGURA_DADOS; i++) begin
      if (d[i]) begin
        case (3'(i))
          3'd0:    c = 3'b010;
          3'd1:    c = 3'b100;
          3'd2:    c = 3'b011;
          3'd3:    c = 3'b001;
          3'd4:    c = 3'b101;
          3'd5:    c = 3'b110;
          default: c = 3'b111;
        endcase
      end
    end
    return c;
  endfunction

  logic [2:0]             r_cor;
  logic [LARGURA_PWM-1:0] r_contador_pwm;
  logic [LARGURA_PWM-1:0] r_duty;
  logic [1:0]             r_modo;
  logic [QW-1:0]          r_quadros;
  logic                   r_fase;

  logic                   w_fim;
  logic                   w_muda_modo;
  logic                   w_ligado;
  logic [QW-1:0]          w_quadros_prox;
  logic                   w_fase_prox;
  logic [LARGURA_PWM-1:0] w_duty_prox;

`ifdef DRIVER_RGB_FADE_EN
  logic [LARGURA_PWM-1:0] r_rampa;
  logic [LARGURA_PWM-1:0] w_rampa_prox;
  estado_t                r_estado;
  estado_t                w_estado_prox;
`endif

  assign w_fim       = en & (r_contador_pwm == PWM_MAX);
  assign w_muda_modo = (modo != r_modo);
  assign w_ligado    = (r_contador_pwm < r_duty) || (r_duty == PWM_MAX);

  // Colour latch and error flag; loads on carrega regardless of en.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cor <= 3'b000;
      erro  <= 1'b0;
    end else if (carrega) begin
      if (eh_one_hot(dados)) begin
        r_cor <= cor_de(dados);
        erro  <= 1'b0;
      end else begin
        r_cor <= 3'b000;
        erro  <= 1'b1;
      end
    end
  end

  // Blink frame counter and phase for the frame about to start.
  always_comb begin
    w_quadros_prox = r_quadros;
    w_fase_prox    = r_fase;
    if (w_muda_modo) begin
      w_quadros_prox = {QW{1'b0}};
      w_fase_prox    = 1'b1;
    end else if (r_quadros == QUADRO_ULTIMO) begin
      w_quadros_prox = {QW{1'b0}};
      w_fase_prox    = ~r_fase;
    end else begin
      w_quadros_prox = r_quadros + QW'(1);
      w_fase_prox    = r_fase;
    end
  end

`ifdef DRIVER_RGB_FADE_EN
  // Fade ramp next state: climb to the sampled brightness, then back to zero.
  always_comb begin
    w_rampa_prox  = r_rampa;
    w_estado_prox = r_estado;
    if (w_muda_modo) begin
      w_rampa_prox  = {LARGURA_PWM{1'b0}};
      w_estado_prox = SUBINDO;
    end else begin
      case (r_estado)
        SUBINDO: begin
          if (r_rampa >= brilho) begin
            w_rampa_prox  = brilho;
            w_estado_prox = DESCENDO;
          end else begin
            w_rampa_prox  = r_rampa + LARGURA_PWM'(1);
            w_estado_prox = SUBINDO;
          end
        end
        DESCENDO: begin
          if (r_rampa == {LARGURA_PWM{1'b0}}) begin
            w_rampa_prox  = r_rampa;
            w_estado_prox = SUBINDO;
          end else begin
            w_rampa_prox  = r_rampa - LARGURA_PWM'(1);
            w_estado_prox = DESCENDO;
          end
        end
        default: begin
          w_rampa_prox  = {LARGURA_PWM{1'b0}};
          w_estado_prox = SUBINDO;
        end
      endcase
    end
  end

  // Fade ramp and state registers; advance only at frame end, cleared while disabled.
  always_ff @(posedge clock) begin
    if (reset || !en) begin
      r_rampa  <= {LARGURA_PWM{1'b0}};
      r_estado <= SUBINDO;
    end else if (w_fim) begin
      r_rampa  <= w_rampa_prox;
      r_estado <= w_estado_prox;
    end
  end
`endif

  // Duty for the next frame from the incoming mode and brightness.
  always_comb begin
    w_duty_prox = brilho;
    case (modo)
      2'b01: begin
        if (w_fase_prox) begin
          w_duty_prox = brilho;
        end else begin
          w_duty_prox = {LARGURA_PWM{1'b0}};
        end
      end
`ifdef DRIVER_RGB_FADE_EN
      2'b10:   w_duty_prox = w_rampa_prox;
`endif
      default: w_duty_prox = brilho;
    endcase
  end

  // PWM counter, frame-end pulse and frame-aligned sampling of duty/mode/blink state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_contador_pwm <= {LARGURA_PWM{1'b0}};
      r_duty         <= {LARGURA_PWM{1'b0}};
      r_modo         <= 2'b00;
      r_quadros      <= {QW{1'b0}};
      r_fase         <= 1'b1;
      fim_quadro     <= 1'b0;
    end else if (!en) begin
      r_contador_pwm <= {LARGURA_PWM{1'b0}};
      r_quadros      <= {QW{1'b0}};
      r_fase         <= 1'b1;
      fim_quadro     <= 1'b0;
    end else begin
      r_contador_pwm <= r_contador_pwm + LARGURA_PWM'(1);
      fim_quadro     <= w_fim;
      if (w_fim) begin
        r_duty    <= w_duty_prox;
        r_modo    <= modo;
        r_quadros <= w_quadros_prox;
        r_fase    <= w_fase_prox;
      end
    end
  end

  // Registered LED drive: one cycle behind the counter/duty compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      leds_rgb <= 3'b000;
    end else if (!en) begin
      leds_rgb <= 3'b000;
    end else begin
      leds_rgb <= r_cor & {3{w_ligado}};
    end
  end

endmodule

// File: tb/tb_driver_leds_rgb.sv
// Self-checking bench for driver_leds_rgb (16-cycle frames, 2 frames per blink half).
// The reference model tracks frames since the last animation restart and derives
// blink phase and fade duty arithmetically from that count.
module tb_driver_leds_rgb;

  localparam int LD   = 8;
  localparam int LP   = 4;
  localparam int DIV  = 2;
  localparam int MAXC = 15;

  logic          clock;
  logic          reset;
  logic          en;
  logic          carrega;
  logic [LD-1:0] dados;
  logic [LP-1:0] brilho;
  logic [1:0]    modo;
  logic [2:0]    leds_rgb;
  logic          erro;
  logic          fim_quadro;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_cnt;
  int         m_duty;
  int         m_k;
  logic [1:0] m_mode;
  logic [2:0] m_cor;
  logic       m_erro;
  logic [2:0] cor_tab [8] = '{3'b010, 3'b100, 3'b011, 3'b001,
                              3'b101, 3'b110, 3'b111, 3'b111};

  driver_leds_rgb #(
    .LARGURA_DADOS(LD),
    .LARGURA_PWM  (LP),
    .DIV_PISCA    (DIV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .carrega   (carrega),
    .dados     (dados),
    .brilho    (brilho),
    .modo      (modo),
    .leds_rgb  (leds_rgb),
    .erro      (erro),
    .fim_quadro(fim_quadro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Triangle wave 0..b..0 with both ends held for one frame.
  function automatic int rampa_esperada(input int k, input int b);
    int p;
    p = k % (2 * b + 2);
    return (p <= b) ? p : (2 * b + 1 - p);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock: predict outputs from pre-edge state, update model, compare.
  task automatic tick();
    logic [2:0] e_leds;
    logic       e_fim;
    logic       on;
    if (reset) begin
      m_cnt = 0; m_duty = 0; m_k = 0; m_mode = 2'b00; m_cor = 3'b000; m_erro = 1'b0;
      e_leds = 3'b000;
      e_fim  = 1'b0;
    end else begin
      on     = (m_cnt < m_duty) || (m_duty == MAXC);
      e_leds = (en && on) ? m_cor : 3'b000;
      e_fim  = en && (m_cnt == MAXC);
      if (carrega) begin
        if ($countones(dados) == 1) begin
          for (int i = 0; i < LD; i++) if (dados[i]) m_cor = cor_tab[i];
          m_erro = 1'b0;
        end else begin
          m_cor  = 3'b000;
          m_erro = 1'b1;
        end
      end
      if (!en) begin
        m_cnt = 0;
        m_k   = 0;
      end else begin
        if (m_cnt == MAXC) begin
          if (modo != m_mode) begin
            m_k    = 0;
            m_mode = modo;
          end else begin
            m_k++;
          end
          case (modo)
            2'b01:   m_duty = (((m_k / DIV) % 2) == 0) ? int'(brilho) : 0;
`ifdef DRIVER_RGB_FADE_EN
            2'b10:   m_duty = rampa_esperada(m_k, int'(brilho));
`endif
            default: m_duty = int'(brilho);
          endcase
        end
        m_cnt = (m_cnt + 1) % (MAXC + 1);
      end
    end
    @(posedge clock);
    #1;
    check("leds_rgb",   {5'b00000, leds_rgb},   {5'b00000, e_leds});
    check("erro",       {7'b0000000, erro},     {7'b0000000, m_erro});
    check("fim_quadro", {7'b0000000, fim_quadro}, {7'b0000000, e_fim});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic carregar(input logic [LD-1:0] d);
    dados   = d;
    carrega = 1'b1;
    tick();
    carrega = 1'b0;
  endtask

  initial begin
    int md;
    int prev_md;
    reset = 1'b1; en = 1'b0; carrega = 1'b0; dados = '0; brilho = '0; modo = 2'b00;
    run(2);
    check("reset_leds", {5'b00000, leds_rgb}, 8'h00);

    // red at duty 4
    reset = 1'b0; en = 1'b1; brilho = 4'd4; modo = 2'b00;
    carregar(8'b0000_0001);
    run(40);

    // invalid code, then yellow
    carregar(8'b0000_0110);
    run(20);
    carregar(8'b0000_0100);
    run(20);

    // green fully on, then brilho change mid-frame
    brilho = 4'd15;
    carregar(8'b0000_1000);
    run(40);
    run(5);
    brilho = 4'd2;
    run(40);

    // blink blue at duty 8
    modo = 2'b01; brilho = 4'd8;
    carregar(8'b0000_0010);
    run(16 * 7);

    // fade (or fixed without the macro) at brilho 3
    modo = 2'b10; brilho = 4'd3;
    carregar(8'b0001_0000);
    run(16 * 12 + 5);

    // en dropped mid-frame, then re-enabled
    en = 1'b0;
    run(7);
    carregar(8'b0010_0000);
    en = 1'b1;
    run(16 * 5 + 3);

    // reset mid-fade
    reset = 1'b1;
    tick();
    check("reset_mid_erro", {7'b0000000, erro}, 8'h00);
    reset = 1'b0;
    carregar(8'b1000_0000);
    run(40);

    // randomized segments
    prev_md = 2;
    for (int s = 0; s < 30; s++) begin
      md   = $urandom_range(0, 3);
      modo = 2'(md);
      if (!(md == 2 && prev_md == 2)) brilho = 4'($urandom);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          if ($urandom_range(0, 3) == 0) dados = 8'($urandom);
          else dados = 8'd1 << $urandom_range(0, 7);
          carrega = 1'b1;
        end else begin
          carrega = 1'b0;
        end
        if (md != 2 && $urandom_range(0, 29) == 0) brilho = 4'($urandom);
        if ($urandom_range(0, 99) == 0) en = ~en;
        tick();
      end
      carrega = 1'b0;
      en      = 1'b1;
      prev_md = md;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
